// File: rtl/dmem_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_rmw_ctrl
//   Data-memory access controller between the EX/MEM request port and a
//   single-port, word-wide synchronous RAM without byte enables. Byte and
//   half-word stores are carried out as read-modify-write. Loads return the
//   raw RAM word plus the low two address bits so the load-extend stage can
//   pick and extend the lane. Misaligned or reserved-size requests are
//   answered with rsp_err and never touch the RAM.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_size          00 word, 01 half, 10 byte, 11 reserved
//   req_addr          byte address (bits above ADDR_W+1 ignored, wraps)
//   req_wdata         store data, right-aligned
//   rsp_valid/ready   response handshake; response held until taken
//   rsp_rdata         raw RAM word for loads, 0 for stores and errors
//   rsp_addr_tail     req_addr[1:0] of the answered request
//   rsp_err           misaligned / reserved size, no RAM access made
//   mem_en/we/addr    RAM cycle enable, write strobe, word address
//   mem_wdata         RAM write word
//   mem_rdata         RAM read word, valid the cycle after a read cycle
// ---------------------------------------------------------------------------
module dmem_rmw_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_addr_tail,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t      state_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic [31:0] wbuf_r;

    // Address bits above the RAM range are deliberately dropped (wrap).
    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    // Reserved size, odd half-word address or non word-aligned word address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] tail);
        logic bad;
        case (size)
            SZ_WORD: bad = (tail != 2'b00);
            SZ_HALF: bad = tail[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replace the addressed byte / half-word lane of the old RAM word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  tail);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: begin
                case (tail)
                    2'b00:   w[7:0]   = data[7:0];
                    2'b01:   w[15:8]  = data[7:0];
                    2'b10:   w[23:16] = data[7:0];
                    2'b11:   w[31:24] = data[7:0];
                    default: w        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (tail[1]) begin
                    w[31:16] = data[15:0];
                end else begin
                    w[15:0] = data[15:0];
                end
            end
            default: w = old_word;
        endcase
        return w;
    endfunction

    // Controller FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            wbuf_r        <= 32'd0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'd0;
            rsp_addr_tail <= 2'b00;
            rsp_err       <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // req_ready is always high here, so req_valid alone accepts.
                    if (req_valid) begin
                        req_ready     <= 1'b0;
                        we_r          <= req_we;
                        size_r        <= req_size;
                        wbuf_r        <= req_wdata;
                        rsp_addr_tail <= req_addr[1:0];
                        rsp_rdata     <= 32'd0;
                        mem_addr      <= req_addr[ADDR_W+1:2];
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state_r   <= S_RESP;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            rsp_err   <= 1'b0;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                            state_r   <= S_WR;
                        end else begin
                            rsp_err <= 1'b0;
                            mem_en  <= 1'b1;
                            mem_we  <= 1'b0;
                            state_r <= S_RD;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RD: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // mem_rdata is valid now: either return it or merge and write back.
                    if (we_r) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_lanes(mem_rdata, wbuf_r, size_r, rsp_addr_tail);
                        state_r   <= S_WR;
                    end else begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= 1'b1;
                        state_r   <= S_RESP;
                    end
                end
                S_WR: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_r   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_rmw_ctrl
//   Self-checking bench for dmem_rmw_ctrl. A behavioural sync RAM is attached
//   to the memory port; a separate reference memory is updated with plain
//   mask/shift arithmetic and compared against the RAM after every request.
// ---------------------------------------------------------------------------
module tb_dmem_rmw_ctrl;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_addr_tail;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_addr_tail(rsp_addr_tail), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM plus access counters.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt++;
            end else begin
                mem_rdata <= ram[mem_addr];
                rd_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata,          32'd0);
        check({tag, "_tail"},      {30'd0, rsp_addr_tail}, 32'd0);
        check({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
        check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({tag, "_mem_addr"},  {21'd0, mem_addr},  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
    endtask

    // One complete request; called at a negedge with the DUT idle.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic        err;
        logic [10:0] idx;
        logic [31:0] old_word, exp_rdata, mask;
        int          sh, exp_lat, lat, exp_rd, exp_wr;

        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd0 && addr[1:0] != 2'd0);
        idx = addr[12:2];
        old_word = ref_mem[idx];
        exp_rdata = (err || we) ? 32'd0 : old_word;
        if (err)                exp_lat = 1;
        else if (!we)           exp_lat = 3;
        else if (size == 2'd0)  exp_lat = 2;
        else                    exp_lat = 4;
        exp_rd = (!err && !(we && size == 2'd0)) ? 1 : 0;
        exp_wr = (!err && we) ? 1 : 0;
        if (!err && we) begin
            if (size == 2'd0) begin
                ref_mem[idx] = wdata;
            end else begin
                sh   = (size == 2'd2) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
                mask = ((size == 2'd2) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                ref_mem[idx] = (old_word & ~mask) | ((wdata << sh) & mask);
            end
        end

        check({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
        rd_cnt    = 0;
        wr_cnt    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"},   lat, exp_lat);
        check({tag, "_rdata"},     rsp_rdata, exp_rdata);
        check({tag, "_tail"},      {30'd0, rsp_addr_tail}, {30'd0, addr[1:0]});
        check({tag, "_err"},       {31'd0, rsp_err}, {31'd0, err});
        check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_hold_tail"},  {30'd0, rsp_addr_tail}, {30'd0, addr[1:0]});
            check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_after"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_reads"},  rd_cnt, exp_rd);
        check({tag, "_writes"}, wr_cnt, exp_wr);
        check({tag, "_ram"},    ram[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a = $urandom;
            ram[i]     <= a;
            ref_mem[i]  = a;
        end
        ram[4]     <= 32'h1122_3344;
        ref_mem[4]  = 32'h1122_3344;
        ram[5]     <= 32'h0000_0000;
        ref_mem[5]  = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_req("lw_0x10", 1'b0, 2'd0, 32'h0000_0010, 32'h0, 0);
        run_req("sb_0x12", 1'b1, 2'd2, 32'h0000_0012, 32'h0000_00AB, 0);
        check("sb_ram4_value", ram[4], 32'h11AB_3344);
        run_req("sh_0x16", 1'b1, 2'd1, 32'h0000_0016, 32'h0000_BEEF, 0);
        check("sh_ram5_value", ram[5], 32'hBEEF_0000);
        run_req("sw_0x14", 1'b1, 2'd0, 32'h0000_0014, 32'hCAFE_F00D, 0);
        run_req("lw_mis",  1'b0, 2'd0, 32'h0000_0013, 32'h0, 0);
        run_req("sh_mis",  1'b1, 2'd1, 32'h0000_0011, 32'h1234_5678, 0);
        run_req("sz_rsvd", 1'b0, 2'd3, 32'h0000_0010, 32'h0, 0);
        run_req("lb_hold", 1'b0, 2'd2, 32'h0000_0013, 32'h0, 5);
        run_req("sw_wrap", 1'b1, 2'd0, 32'hFFFF_E008, 32'h0BAD_F00D, 0);
        run_req("lw_wrap", 1'b0, 2'd0, 32'h0000_2008, 32'h0, 1);

        // Reset while a byte store waits for its read data.
        rd_cnt    = 0;
        wr_cnt    = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        check("mid_rst_writes", wr_cnt, 32'd0);
        check("mid_rst_ram4", ram[4], ref_mem[4]);
        @(negedge clk);

        // Randomised traffic, mostly aligned.
        for (int n = 0; n < 60; n++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0]   = 1'b0;
            end
            run_req("rand", 1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
